// File: rtl/tc3_pkg.sv
// Shared definitions for the 3-way Toom-Cook style GF(2) multiplier sequencer:
// default geometry, controller states and the fixed limb-product schedule.
package tc3_pkg;

  localparam int TC3_AW  = 192;
  localparam int TC3_BW  = 150;
  localparam int TC3_LA  = TC3_AW / 3;
  localparam int TC3_LB  = TC3_BW / 3;
  localparam int TC3_PPW = TC3_LA + TC3_LB - 1;
  localparam int TC3_CW  = TC3_AW + TC3_BW;

  typedef enum logic [2:0] {IDLE, MUL, ACC, SKIP, DONE} state_t;

  // One nibble {i,j} per product k, k=0 in the low nibble:
  // (2,2),(2,1),(1,2),(2,0),(1,1),(0,2),(1,0),(0,1),(0,0)
  localparam logic [35:0] SCHED = 36'h01425869A;

  function automatic logic [1:0] sched_i(input logic [3:0] k);
    return SCHED[{k, 2'b10} +: 2];
  endfunction

  function automatic logic [1:0] sched_j(input logic [3:0] k);
    return SCHED[{k, 2'b00} +: 2];
  endfunction

endpackage

// File: rtl/tc3_limb_mul.sv
// Bit-serial LA x LB carry-less limb multiplier: one bit of a_i per enabled
// cycle, shifted copy of b_j folded into the partial product.
module tc3_limb_mul
  import tc3_pkg::*;
#(
  parameter int LA = TC3_LA,
  parameter int LB = TC3_LB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     a_bit_i,
  input  logic [LB-1:0]            b_limb_i,
  input  logic [$clog2(LA)-1:0]    t_i,
  output logic [LA+LB-2:0]         pp_o
);
  localparam int PPW = LA + LB - 1;

  logic [PPW-1:0] pp_q, pp_d;

  always_comb begin
    pp_d = pp_q;
    if (clr_i)                pp_d = '0;
    else if (en_i && a_bit_i) pp_d = pp_q ^ (PPW'(b_limb_i) << t_i);
  end

  always_ff @(posedge clk) begin
    if (rst) pp_q <= '0;
    else     pp_q <= pp_d;
  end

  assign pp_o = pp_q;

endmodule

// File: rtl/tc3_mul_sched.sv
// Sequencer that walks the nine limb products through one shared bit-serial
// multiplier and XOR-accumulates the shifted partial products into c.
module tc3_mul_sched
  import tc3_pkg::*;
#(
  parameter int AW        = TC3_AW,
  parameter int BW        = TC3_BW,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [AW-1:0]    a_i,
  input  logic [BW-1:0]    b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [AW+BW-1:0] c_o,
  output logic             busy_o
);
  localparam int LA  = AW / 3;
  localparam int LB  = BW / 3;
  localparam int PPW = LA + LB - 1;
  localparam int CW  = AW + BW;
  localparam int TW  = $clog2(LA);

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [BW-1:0]   b_q, b_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   c_q, c_d;
  logic [3:0]      k_q, k_d;
  logic [TW-1:0]   t_q, t_d;

  logic [1:0]      cur_i, cur_j, nxt_i, nxt_j;
  logic [LA-1:0]   a_limb;
  logic [LB-1:0]   b_limb;
  logic [PPW-1:0]  pp;
  logic            pp_clr, pp_en;
  logic [3:0]      nk;
  logic [AW-1:0]   na;
  logic [BW-1:0]   nb;
  logic            nskip;
  state_t          next_prod;
  int unsigned     sh;

  function automatic logic [LA-1:0] limb_a(input logic [AW-1:0] v, input logic [1:0] idx);
    return v[int'(idx)*LA +: LA];
  endfunction

  function automatic logic [LB-1:0] limb_b(input logic [BW-1:0] v, input logic [1:0] idx);
    return v[int'(idx)*LB +: LB];
  endfunction

  assign cur_i  = sched_i(k_q);
  assign cur_j  = sched_j(k_q);
  assign a_limb = limb_a(a_q, cur_i);
  assign b_limb = limb_b(b_q, cur_j);
  assign sh     = int'(cur_i) * LA + int'(cur_j) * LB;

  // Look ahead at the product about to start: from IDLE it is product 0 of the
  // operands being accepted, otherwise product k+1 of the registered ones.
  assign nk        = (state_q == IDLE || k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
  assign na        = (state_q == IDLE) ? a_i : a_q;
  assign nb        = (state_q == IDLE) ? b_i : b_q;
  assign nxt_i     = sched_i(nk);
  assign nxt_j     = sched_j(nk);
  assign nskip     = SKIP_ZERO && (limb_a(na, nxt_i) == '0 || limb_b(nb, nxt_j) == '0);
  assign next_prod = nskip ? SKIP : MUL;

  tc3_limb_mul #(.LA(LA), .LB(LB)) u_limb_mul (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (pp_clr),
    .en_i     (pp_en),
    .a_bit_i  (a_limb[t_q]),
    .b_limb_i (b_limb),
    .t_i      (t_q),
    .pp_o     (pp)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    c_d         = c_q;
    k_d         = k_q;
    t_d         = t_q;
    pp_clr      = 1'b0;
    pp_en       = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          pp_clr  = 1'b1;
          k_d     = 4'd0;
          t_d     = '0;
          state_d = next_prod;
        end
      end
      MUL: begin
        pp_en = 1'b1;
        t_d   = t_q + 1'b1;
        if (t_q == TW'(LA - 1)) begin
          t_d     = '0;
          state_d = ACC;
        end
      end
      ACC, SKIP: begin
        if (state_q == ACC) begin
          acc_d  = acc_q ^ (CW'(pp) << sh);
          pp_clr = 1'b1;
        end
        if (k_q == 4'd8) state_d = DONE;
        else begin
          k_d     = k_q + 4'd1;
          state_d = next_prod;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // c is captured once on entry to DONE, so it survives the transfer.
    if (state_d == DONE && state_q != DONE) c_d = acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      k_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      k_q     <= k_d;
      t_q     <= t_d;
    end
  end

  assign c_o    = c_q;
  assign busy_o = (state_q != IDLE);

endmodule
